// File: rtl/onehot_decoder_pkg.sv
// onehot_decoder_pkg
//   Shared widths, FSM state encoding and small helpers for the one-hot
//   decoder and its index FIFO.
//   IDX_W    : width of a binary bit index (0..7)
//   ONEHOT_W : width of the expanded one-hot word
//   HOLD_W   : width of the hold-length input and hold counter
package onehot_decoder_pkg;

  localparam int unsigned IDX_W    = 3;
  localparam int unsigned ONEHOT_W = 8;
  localparam int unsigned HOLD_W   = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

  function automatic logic [ONEHOT_W-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    return ONEHOT_W'(1) << idx;
  endfunction

  // A hold length of 0 behaves like 1, so both load a counter of 0.
  function automatic logic [HOLD_W-1:0] hold_reload(input logic [HOLD_W-1:0] len);
    return (len == '0) ? '0 : len - 1'b1;
  endfunction

endpackage

// File: rtl/index_fifo.sv
// index_fifo
//   Small synchronous FIFO of bit indices, DEPTH entries (power of two).
//   clk, rst_n : clock, synchronous active-low reset
//   push, din  : write din at the tail (ignored when full)
//   pop, dout  : remove the head (ignored when empty); dout shows the head
//   full/empty : registered occupancy flags
module index_fifo
  import onehot_decoder_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [IDX_W-1:0] din,
  input  logic             pop,
  output logic [IDX_W-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [IDX_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/onehot_decoder.sv
// onehot_decoder
//   Queues binary indices and drives each as a one-hot word for hold_len
//   cycles (0 counts as 1), back-to-back when more indices are queued.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid/in_ready    : index handshake; in_index is the bit position
//   hold_len             : cycles per word, sampled when a word is popped
//   out_onehot/out_valid : registered decoded word and its qualifier
//   busy                 : a word is being driven or indices are queued
module onehot_decoder
  import onehot_decoder_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [IDX_W-1:0]    in_index,
  output logic                in_ready,
  input  logic [HOLD_W-1:0]   hold_len,
  output logic [ONEHOT_W-1:0] out_onehot,
  output logic                out_valid,
  output logic                busy
);

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              fifo_full;
  logic              fifo_empty;
  logic [IDX_W-1:0]  head;
  logic              push;
  logic              pop;

  // Ready comes from the registered full flag only, so a pop in the same
  // cycle never opens a slot early.
  assign in_ready = rst_n & ~fifo_full;
  assign push     = in_valid & in_ready;
  assign busy     = out_valid | ~fifo_empty;

  always_comb begin
    pop = 1'b0;
    if (!fifo_empty) begin
      case (state)
        IDLE:    pop = 1'b1;
        DRIVE:   pop = (hold_cnt == '0);
        default: pop = 1'b0;
      endcase
    end
  end

  index_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (in_index),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      out_onehot <= '0;
      out_valid  <= 1'b0;
      hold_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            out_onehot <= idx_to_onehot(head);
            out_valid  <= 1'b1;
            hold_cnt   <= hold_reload(hold_len);
            state      <= DRIVE;
          end
        end
        DRIVE: begin
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
          end else if (pop) begin
            out_onehot <= idx_to_onehot(head);
            hold_cnt   <= hold_reload(hold_len);
          end else begin
            out_onehot <= '0;
            out_valid  <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          out_onehot <= '0;
          out_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_onehot_decoder.sv
// tb_onehot_decoder
//   Directed bench for onehot_decoder with DEPTH=4: reset values, single
//   word, hold length, back-to-back, full FIFO, mid-drive reset and a sweep
//   of all eight indices with random hold lengths.
module tb_onehot_decoder;
  import onehot_decoder_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic [IDX_W-1:0]    in_index;
  logic                in_ready;
  logic [HOLD_W-1:0]   hold_len;
  logic [ONEHOT_W-1:0] out_onehot;
  logic                out_valid;
  logic                busy;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  onehot_decoder #(
    .DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_index   (in_index),
    .in_ready   (in_ready),
    .hold_len   (hold_len),
    .out_onehot (out_onehot),
    .out_valid  (out_valid),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Run monitor: collapses consecutive identical valid words into runs.
  logic [ONEHOT_W-1:0] run_word [$];
  int unsigned         run_len  [$];
  logic [ONEHOT_W-1:0] exp_word [$];
  int unsigned         exp_len  [$];
  logic [ONEHOT_W-1:0] cur_word;
  int unsigned         cur_len = 0;

  always @(negedge clk) begin
    if (out_valid) check("onehot_bits", $countones(out_onehot), 1);
    if (out_valid && cur_len != 0 && out_onehot == cur_word) begin
      cur_len++;
    end else begin
      if (cur_len != 0) begin
        run_word.push_back(cur_word);
        run_len.push_back(cur_len);
      end
      if (out_valid) begin
        cur_word = out_onehot;
        cur_len  = 1;
      end else begin
        cur_len = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_runs();
    run_word.delete();
    run_len.delete();
    exp_word.delete();
    exp_len.delete();
  endtask

  task automatic wait_idle(input string tag, input int unsigned budget);
    int unsigned n = 0;
    while ((busy || out_valid) && n < budget) begin
      step();
      n++;
    end
    check({tag, "_idle"}, busy, 0);
    step();
  endtask

  task automatic compare_runs(input string tag);
    int unsigned n;
    check({tag, "_count"}, run_word.size(), exp_word.size());
    n = (run_word.size() < exp_word.size()) ? run_word.size() : exp_word.size();
    for (int unsigned i = 0; i < n; i++) begin
      check($sformatf("%s_word%0d", tag, i), run_word[i], exp_word[i]);
      check($sformatf("%s_len%0d", tag, i), run_len[i], exp_len[i]);
    end
    clear_runs();
  endtask

  initial begin
    logic [IDX_W-1:0]  full_idx [6];
    int unsigned       accepted;
    logic              rdy;
    logic [HOLD_W-1:0] h;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_index = '0;
    hold_len = '0;

    // Reset state
    step();
    step();
    check("rst_onehot", out_onehot, 8'h00);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ready_low", in_ready, 0);
    rst_n = 1'b1;
    step();
    check("ready_after_rst", in_ready, 1);

    // Single word, hold_len=0, index 5
    hold_len = 4'd0;
    in_valid = 1'b1;
    in_index = 3'd5;
    step();
    in_valid = 1'b0;
    check("single_latency", out_valid, 0);
    step();
    check("single_word", out_onehot, 8'h20);
    check("single_valid", out_valid, 1);
    step();
    check("single_end_word", out_onehot, 8'h00);
    check("single_end_valid", out_valid, 0);
    check("single_end_busy", busy, 0);

    // Hold length 3, index 0; hold_len change mid-word must not matter
    hold_len = 4'd3;
    in_valid = 1'b1;
    in_index = 3'd0;
    step();
    in_valid = 1'b0;
    step();
    check("hold_c1", out_onehot, 8'h01);
    hold_len = 4'd0;
    step();
    check("hold_c2", out_onehot, 8'h01);
    step();
    check("hold_c3", out_onehot, 8'h01);
    step();
    check("hold_end", out_onehot, 8'h00);
    check("hold_end_valid", out_valid, 0);

    // Back-to-back 7,3,1 with hold_len=2
    hold_len = 4'd2;
    in_valid = 1'b1;
    in_index = 3'd7;
    step();
    check("b2b_c0", out_onehot, 8'h00);
    in_index = 3'd3;
    step();
    check("b2b_c1", out_onehot, 8'h80);
    in_index = 3'd1;
    step();
    check("b2b_c2", out_onehot, 8'h80);
    in_valid = 1'b0;
    step();
    check("b2b_c3", out_onehot, 8'h08);
    step();
    check("b2b_c4", out_onehot, 8'h08);
    step();
    check("b2b_c5", out_onehot, 8'h02);
    step();
    check("b2b_c6", out_onehot, 8'h02);
    check("b2b_c6_valid", out_valid, 1);
    step();
    check("b2b_end", out_onehot, 8'h00);

    // Full FIFO: in_valid held 6 cycles, hold_len=15
    step();
    clear_runs();
    full_idx = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    hold_len = 4'd15;
    in_valid = 1'b1;
    accepted = 0;
    for (int unsigned c = 0; c < 6; c++) begin
      in_index = full_idx[accepted];
      rdy      = in_ready;
      if (c == 5) check("full_ready_c5", rdy, 0);
      step();
      if (rdy) accepted++;
    end
    check("full_ready_low", in_ready, 0);
    check("full_accepted", accepted, 5);
    in_valid = 1'b0;
    for (int unsigned i = 1; i <= 5; i++) begin
      exp_word.push_back(8'(1 << i));
      exp_len.push_back(15);
    end
    wait_idle("full", 200);
    compare_runs("full");

    // Reset while driving 8'h10 with two entries queued
    hold_len = 4'd6;
    in_valid = 1'b1;
    in_index = 3'd4;
    step();
    in_index = 3'd2;
    step();
    in_index = 3'd3;
    step();
    in_valid = 1'b0;
    check("rstmid_pre_word", out_onehot, 8'h10);
    rst_n = 1'b0;
    step();
    check("rstmid_word", out_onehot, 8'h00);
    check("rstmid_valid", out_valid, 0);
    check("rstmid_busy", busy, 0);
    rst_n = 1'b1;
    #1;
    check("rstmid_ready", in_ready, 1);
    step();
    clear_runs();
    for (int unsigned i = 0; i < 8; i++) step();
    check("rstmid_no_output", run_word.size(), 0);
    check("rstmid_still_idle", busy, 0);
    clear_runs();

    // All eight indices, random hold lengths
    for (int unsigned i = 0; i < 8; i++) begin
      h        = 4'($urandom_range(15, 0));
      hold_len = h;
      in_valid = 1'b1;
      in_index = 3'(i);
      step();
      in_valid = 1'b0;
      exp_word.push_back(8'(1 << i));
      exp_len.push_back((h == 0) ? 1 : int'(h));
      wait_idle($sformatf("sweep%0d", i), 40);
    end
    compare_runs("sweep");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/onehot_decoder.md
ONEHOT_DECODER -- requirements
Module: onehot_decoder

Interface
REQ-001 The block SHALL have exactly one parameter: DEPTH, default 4, number of index entries the input FIFO holds (power of two, at least 2).
REQ-002 The port clk SHALL be an input, 1 bit wide, and is the single clock; all state changes on its rising edge.
REQ-003 The port rst_n SHALL be an input, 1 bit wide: synchronous, active-low reset.
REQ-004 The port in_valid SHALL be an input, 1 bit wide: the producer offers in_index.
REQ-005 The port in_index SHALL be an input, 3 bits wide: binary bit position 0..7 to be expanded.
REQ-006 The port in_ready SHALL be an output, 1 bit wide: the block accepts in_index this cycle.
REQ-007 The port hold_len SHALL be an input, 4 bits wide: number of cycles each one-hot word is driven; 0 is treated as 1.
REQ-008 The port out_onehot SHALL be an output, 8 bits wide, registered: one-hot word with bit[index] set, or all zeros when idle.
REQ-009 The port out_valid SHALL be an output, 1 bit wide, registered: out_onehot carries a decoded word.
REQ-010 The port busy SHALL be an output, 1 bit wide: out_valid OR FIFO not empty.

Function
REQ-011 A transfer SHALL occur on a rising edge where in_valid and in_ready are both 1; in_index is then written to the FIFO tail.
REQ-012 in_ready SHALL equal NOT(FIFO full), derived from registered state only; a pop in the same cycle SHALL NOT make a full FIFO ready.
REQ-013 The FSM SHALL have two states: IDLE (out_valid=0, out_onehot=0) and DRIVE (out_valid=1).
REQ-014 In IDLE with the FIFO non-empty, the block SHALL pop the head, load out_onehot = 1 << head, load hold counter = max(hold_len,1)-1, and enter DRIVE on that edge.
REQ-015 Latency SHALL be exactly one cycle: an index accepted at edge t into an empty, idle block appears on out_onehot after edge t+1.
REQ-016 In DRIVE with counter > 0, the counter SHALL decrement by 1 per cycle with out_onehot held constant.
REQ-017 In DRIVE with counter = 0 and the FIFO non-empty, the block SHALL pop the next index and load it in the same edge, with no idle gap (back-to-back words).
REQ-018 In DRIVE with counter = 0 and the FIFO empty, the block SHALL return to IDLE, clearing out_onehot and out_valid.
REQ-019 hold_len SHALL be sampled only at pop time; changes while a word is driven SHALL NOT affect that word.
REQ-020 out_onehot SHALL never have more than one bit set; each accepted index SHALL be output exactly once, in acceptance order.
REQ-021 FIFO pointers SHALL wrap modulo DEPTH; full/empty SHALL be distinguished by an extra pointer bit or an occupancy count of width log2(DEPTH)+1.
REQ-022 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave occupancy unchanged.

Reset
REQ-023 While rst_n=0 at a rising edge, the block SHALL clear both FIFO pointers and the occupancy, set the state to IDLE, set out_onehot=0 and out_valid=0, and set the hold counter to 0.
REQ-024 in_ready SHALL be 0 while rst_n is 0; no transfer SHALL be accepted in a reset cycle.
REQ-025 A reset applied in the middle of DRIVE SHALL discard the current word and all queued entries; the block SHALL resume from the empty, idle state.

Structure
REQ-026 A shared package SHALL hold IDX_W=3, ONEHOT_W=8, HOLD_W=4 and the IDLE/DRIVE state encoding.
REQ-027 The FIFO SHALL be a separate sub-module named index_fifo (push, pop, data, full, empty); onehot_decoder SHALL contain the FSM, the counter and the decode logic.

Verification
REQ-028 Single word: hold_len=0, push index 5 at edge t -> out_onehot=8'b0010_0000 and out_valid=1 for exactly 1 cycle after edge t+1, then 0.
REQ-029 Hold length: hold_len=3, push index 0 -> out_onehot=8'h01 for 3 consecutive cycles, then IDLE.
REQ-030 Back-to-back: hold_len=2, push 7,3,1 on consecutive cycles -> 8'h80,8'h80,8'h08,8'h08,8'h02,8'h02 with no zero cycle between them, then 8'h00.
REQ-031 Full: hold_len=15 and DEPTH=4, push 6 indices while in_valid is held high -> in_ready falls when occupancy reaches 4, exactly 5 accepted (1 driving + 4 queued), and no index is lost or duplicated.
REQ-032 Reset mid-operation: rst_n=0 for 1 cycle while driving 8'h10 with 2 entries queued -> the next cycle shows out_onehot=0, out_valid=0, busy=0, in_ready=1, and the queued entries are never output.
REQ-033 Exhaustive: push indices 0..7 with random hold_len -> a scoreboard confirms that each word equals 1<<index with the sampled duration.
